// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: bus widths, reset vector, fetch FSM encoding.
// Imported by fetch-stage logic with import cpu_defs::*.
package cpu_defs;

   localparam int ADDR_BUS = 32;
   localparam int DATA_BUS = 32;

   localparam logic [ADDR_BUS-1:0] RESET_PC_DEF = 32'h0000_0000;

   localparam int PC_STEP = 4;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_HOLD = 2'd1,
      S_DROP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, one-outstanding imem request, wrong-path drop.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_wait counters.
import cpu_defs::*;

module inst_fetch_unit #(
   parameter int ADDR_WIDTH = ADDR_BUS,
   parameter int DATA_WIDTH = DATA_BUS,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic [DATA_WIDTH-1:0] inst_out,
   output logic                  bubble_out
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]           perf_fetched,
   output logic [31:0]           perf_wait
`endif
);

   fetch_state_t          state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] drop_addr;
   logic [DATA_WIDTH-1:0] inst_buf;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic [ADDR_WIDTH-1:0] target;

   assign pc_next = pc + ADDR_WIDTH'(PC_STEP);
   assign target  = redirect_pc & ~ADDR_WIDTH'(3);

   // Presentation to memory and to the fetch/decode register
   always_comb begin
      imem_req   = 1'b0;
      imem_addr  = pc;
      pc_out     = pc;
      inst_out   = '0;
      bubble_out = 1'b1;
      if (rst_n) begin
         unique case (state)
            S_REQ: begin
               imem_req   = 1'b1;
               inst_out   = imem_rdata;
               bubble_out = !imem_ack;
            end
            S_HOLD: begin
               inst_out   = inst_buf;
               bubble_out = 1'b0;
            end
            S_DROP: begin
               imem_req   = 1'b1;
               imem_addr  = drop_addr;
            end
            default: ;
         endcase
         if (redirect) bubble_out = 1'b1;
      end
   end

   // PC, FSM and hold buffer; redirect outranks ack and stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_REQ;
         pc        <= RESET_PC;
         drop_addr <= RESET_PC;
         inst_buf  <= '0;
      end else if (redirect) begin
         pc <= target;
         unique case (state)
            S_REQ: begin
               if (!imem_ack) begin
                  drop_addr <= pc;
                  state     <= S_DROP;
               end
            end
            S_HOLD: state <= S_REQ;
            S_DROP: if (imem_ack) state <= S_REQ;
            default: state <= S_REQ;
         endcase
      end else begin
         unique case (state)
            S_REQ: begin
               if (imem_ack && !stall) begin
                  pc <= pc_next;
               end else if (imem_ack) begin
                  inst_buf <= imem_rdata;
                  state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  pc    <= pc_next;
                  state <= S_REQ;
               end
            end
            S_DROP: if (imem_ack) state <= S_REQ;
            default: state <= S_REQ;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic delivered;
   logic waiting;

   assign delivered = !bubble_out && !stall;
   assign waiting   = imem_req && !imem_ack && (state != S_HOLD);

   // Saturating delivery and memory-wait counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_wait    <= '0;
      end else begin
         if (delivered && (perf_fetched != '1))
            perf_fetched <= perf_fetched + 32'd1;
         if (waiting && (perf_wait != '1))
            perf_wait <= perf_wait + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit (default build).
// Memory is either zero-wait (ack = req) or driven step by step.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] inst_out;
   logic        bubble_out;

   logic        zw;
   logic        m_ack;
   logic [31:0] m_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   assign imem_ack   = zw ? imem_req : m_ack;
   assign imem_rdata = zw ? (imem_addr ^ 32'hA5A5_0000) : m_rdata;

   always #5 clk = ~clk;

   inst_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .pc_out      (pc_out),
      .inst_out    (inst_out),
      .bubble_out  (bubble_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one clock, land 1 time unit after the falling edge
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      zw          = 1'b1;
      m_ack       = 1'b0;
      m_rdata     = '0;

      #12;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_bub", {31'd0, bubble_out}, 32'd1);
      chk("rst_inst", inst_out, 32'h0);
      chk("rst_pc", pc_out, 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("first_bub", {31'd0, bubble_out}, 32'd0);
      chk("first_inst", inst_out, 32'hA5A5_0000);

      for (int i = 0; i < 4; i++) begin
         chk("seq_pc", pc_out, 32'(i * 4));
         chk("seq_bub", {31'd0, bubble_out}, 32'd0);
         cyc();
      end

      zw = 1'b0;
      m_ack = 1'b0;
      #1;
      chk("wait_bub0", {31'd0, bubble_out}, 32'd1);
      chk("wait_addr0", imem_addr, 32'h10);
      cyc();
      chk("wait_bub1", {31'd0, bubble_out}, 32'd1);
      chk("wait_addr1", imem_addr, 32'h10);
      cyc();
      m_ack = 1'b1;
      m_rdata = 32'h1234_5678;
      #1;
      chk("wait_bub2", {31'd0, bubble_out}, 32'd0);
      chk("wait_inst", inst_out, 32'h1234_5678);
      cyc();
      chk("wait_next", pc_out, 32'h14);
      cyc();
      zw = 1'b1;
      cyc();
      cyc();
      chk("pre_stall", pc_out, 32'h20);

      zw = 1'b0;
      m_ack = 1'b1;
      m_rdata = 32'hDEAD_BEEF;
      stall = 1'b1;
      #1;
      chk("stall_bub", {31'd0, bubble_out}, 32'd0);
      chk("stall_inst", inst_out, 32'hDEAD_BEEF);
      cyc();
      m_ack = 1'b0;
      m_rdata = 32'h0;
      #1;
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_inst", inst_out, 32'hDEAD_BEEF);
      chk("hold_pc", pc_out, 32'h20);
      cyc();
      chk("hold_inst2", inst_out, 32'hDEAD_BEEF);
      chk("hold_bub2", {31'd0, bubble_out}, 32'd0);
      stall = 1'b0;
      #1;
      chk("rel_bub", {31'd0, bubble_out}, 32'd0);
      cyc();
      chk("rel_addr", imem_addr, 32'h24);
      chk("rel_req", {31'd0, imem_req}, 32'd1);

      zw = 1'b1;
      for (int i = 0; i < 7; i++) cyc();
      chk("pre_redir", pc_out, 32'h40);

      zw = 1'b0;
      m_ack = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h103;
      #1;
      chk("redir_bub", {31'd0, bubble_out}, 32'd1);
      cyc();
      redirect = 1'b0;
      #1;
      chk("drop_addr0", imem_addr, 32'h40);
      chk("drop_req", {31'd0, imem_req}, 32'd1);
      chk("drop_bub", {31'd0, bubble_out}, 32'd1);
      chk("drop_pc", pc_out, 32'h100);
      cyc();
      chk("drop_addr1", imem_addr, 32'h40);
      m_ack = 1'b1;
      m_rdata = 32'h0000_0BAD;
      #1;
      chk("drop_ack_bub", {31'd0, bubble_out}, 32'd1);
      chk("drop_ack_inst", inst_out, 32'h0);
      cyc();
      m_ack = 1'b0;
      #1;
      chk("tgt_addr", imem_addr, 32'h100);
      chk("tgt_req", {31'd0, imem_req}, 32'd1);

      m_ack = 1'b1;
      m_rdata = 32'h1111_1111;
      stall = 1'b1;
      cyc();
      m_ack = 1'b0;
      #1;
      chk("h2_req", {31'd0, imem_req}, 32'd0);
      redirect = 1'b1;
      redirect_pc = 32'h200;
      #1;
      chk("hredir_bub", {31'd0, bubble_out}, 32'd1);
      cyc();
      redirect = 1'b0;
      #1;
      chk("hredir_addr", imem_addr, 32'h200);
      chk("hredir_req", {31'd0, imem_req}, 32'd1);
      stall = 1'b0;

      zw = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      #1;
      chk("wrap_rbub", {31'd0, bubble_out}, 32'd1);
      cyc();
      redirect = 1'b0;
      #1;
      chk("wrap_pc0", pc_out, 32'hFFFF_FFFC);
      chk("wrap_bub", {31'd0, bubble_out}, 32'd0);
      cyc();
      chk("wrap_pc1", pc_out, 32'h0);
      cyc();
      chk("wrap_pc2", pc_out, 32'h4);

      zw = 1'b0;
      m_ack = 1'b0;
      #1;
      chk("mid_req", {31'd0, imem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_req", {31'd0, imem_req}, 32'd0);
      chk("mrst_pc", pc_out, 32'h0);
      chk("mrst_bub", {31'd0, bubble_out}, 32'd1);
      chk("mrst_inst", inst_out, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      zw = 1'b1;
      #1;
      chk("restart_addr", imem_addr, 32'h0);
      chk("restart_bub", {31'd0, bubble_out}, 32'd0);
      cyc();
      chk("restart_pc", pc_out, 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
